// File: rtl/button_event_arbiter.sv
// Shares the data-memory port between the CPU and the button path: latches presses
// and posts one at a time to a RAM mailbox word, stalling the CPU only when starved.
module button_event_arbiter #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 12,
  parameter int unsigned NUM_BTN       = 16,
  parameter int unsigned EVT_ADDR      = 64,
  parameter int unsigned STARVE_LIMIT  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_BTN-1:0]       btn_pulse,
  input  logic                     cpu_mem_en,
  input  logic                     cpu_wEn,
  input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0]    cpu_dataIn,
  output logic                     cpu_stall,
  output logic                     ram_wEn,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0]    ram_dataIn,
  output logic                     evt_full,
  output logic [7:0]               overflow_cnt
);

  localparam int unsigned IDX_W  = $clog2(NUM_BTN);
  localparam int unsigned WAIT_W = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned CNT_W  = $clog2(NUM_BTN + 1);

  typedef enum logic {
    ST_IDLE,
    ST_ARB
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_BTN-1:0]   pend_q, pend_d;
  logic                 evt_full_q, evt_full_d;
  logic [WAIT_W-1:0]    wait_q, wait_d;
  logic [7:0]           ovf_q, ovf_d;

  logic [IDX_W-1:0]     sel_idx;
  logic [NUM_BTN-1:0]   clr_mask;
  logic [NUM_BTN-1:0]   lost;
  logic [CNT_W-1:0]     lost_cnt;
  logic [8:0]           ovf_sum;
  logic                 at_limit;
  logic                 grant;
  logic                 cpu_wr_evt;
  logic [DATA_WIDTH-1:0] mailbox_word;

  // Lowest pending index wins.
  always_comb begin
    sel_idx = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (pend_q[i]) sel_idx = IDX_W'(i);
    end
  end

  // Reset forces plain pass-through and suppresses any grant or stall.
  assign at_limit     = (wait_q == WAIT_W'(STARVE_LIMIT));
  assign grant        = !reset && (state_q == ST_ARB) && (!cpu_mem_en || at_limit);
  assign cpu_stall    = !reset && (state_q == ST_ARB) && cpu_mem_en && at_limit;
  assign cpu_wr_evt   = cpu_mem_en && cpu_wEn && !grant &&
                        (cpu_addr == ADDRESS_WIDTH'(EVT_ADDR));
  assign mailbox_word = {1'b1, (DATA_WIDTH - 1)'(sel_idx)};

  always_comb begin
    ram_wEn    = cpu_mem_en & cpu_wEn;
    ram_addr   = cpu_addr;
    ram_dataIn = cpu_dataIn;
    if (grant) begin
      ram_wEn    = 1'b1;
      ram_addr   = ADDRESS_WIDTH'(EVT_ADDR);
      ram_dataIn = mailbox_word;
    end
  end

  // Next-state logic: pending mask, overflow counting, mailbox flag and arbitration.
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    clr_mask   = '0;
    lost_cnt   = '0;
    if (grant) clr_mask = NUM_BTN'(1) << sel_idx;
    lost = btn_pulse & pend_q & ~clr_mask;
    for (int i = 0; i < NUM_BTN; i++) begin
      lost_cnt = lost_cnt + CNT_W'(lost[i]);
    end
    ovf_sum    = 9'(ovf_q) + 9'(lost_cnt);
    ovf_d      = ovf_sum[8] ? 8'hFF : ovf_sum[7:0];
    pend_d     = (pend_q & ~clr_mask) | btn_pulse;
    evt_full_d = evt_full_q;
    if (grant) begin
      evt_full_d = 1'b1;
    end else if (cpu_wr_evt) begin
      evt_full_d = cpu_dataIn[DATA_WIDTH-1];
    end
    case (state_q)
      ST_IDLE: begin
        if ((|pend_q) && !evt_full_q) state_d = ST_ARB;
      end
      ST_ARB: begin
        if (grant) begin
          state_d = ST_IDLE;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pend_q     <= '0;
      evt_full_q <= 1'b0;
      wait_q     <= '0;
      ovf_q      <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      evt_full_q <= evt_full_d;
      wait_q     <= wait_d;
      ovf_q      <= ovf_d;
    end
  end

  assign evt_full     = evt_full_q;
  assign overflow_cnt = ovf_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed plus random stimulus for button_event_arbiter, checked every cycle against
// a behavioural model of pending presses, mailbox flag and starvation counting.
module tb_button_event_arbiter;

  localparam int LIMIT = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] btn_pulse;
  logic        cpu_mem_en;
  logic        cpu_wEn;
  logic [11:0] cpu_addr;
  logic [31:0] cpu_dataIn;
  logic        cpu_stall;
  logic        ram_wEn;
  logic [11:0] ram_addr;
  logic [31:0] ram_dataIn;
  logic        evt_full;
  logic [7:0]  overflow_cnt;

  button_event_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .btn_pulse    (btn_pulse),
    .cpu_mem_en   (cpu_mem_en),
    .cpu_wEn      (cpu_wEn),
    .cpu_addr     (cpu_addr),
    .cpu_dataIn   (cpu_dataIn),
    .cpu_stall    (cpu_stall),
    .ram_wEn      (ram_wEn),
    .ram_addr     (ram_addr),
    .ram_dataIn   (ram_dataIn),
    .evt_full     (evt_full),
    .overflow_cnt (overflow_cnt)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Model state: presses waiting, mailbox occupied, waiting for a slot, cycles waited.
  bit [15:0] m_pend;
  bit        m_full;
  bit        m_arb;
  int        m_wait;
  int        m_ovf;
  bit        regs_known = 0;

  int          cyc = 0;
  int          wr_cnt = 0, wr_cyc = 0;
  logic [31:0] wr_data = '0;
  int          st_cnt = 0, st_cyc = 0;
  int          pc = 0, clr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic cycle();
    bit          g, st;
    int          sel, lost;
    bit          e_wen;
    logic [11:0] e_addr;
    logic [31:0] e_data;
    bit [15:0]   np;
    bit          old_nonempty, old_full;
    @(negedge clk);
    sel = 0;
    for (int i = 15; i >= 0; i--) if (m_pend[i]) sel = i;
    st = !reset && m_arb && cpu_mem_en && (m_wait == LIMIT);
    g  = !reset && m_arb && (!cpu_mem_en || (m_wait == LIMIT));
    e_wen  = g ? 1'b1 : (cpu_mem_en & cpu_wEn);
    e_addr = g ? 12'd64 : cpu_addr;
    e_data = g ? (32'h8000_0000 | 32'(sel)) : cpu_dataIn;
    chk("cpu_stall",  32'(cpu_stall), 32'(st));
    chk("ram_wEn",    32'(ram_wEn),   32'(e_wen));
    chk("ram_addr",   32'(ram_addr),  32'(e_addr));
    chk("ram_dataIn", ram_dataIn,     e_data);
    if (regs_known) begin
      chk("evt_full",     32'(evt_full),     32'(m_full));
      chk("overflow_cnt", 32'(overflow_cnt), 32'(m_ovf));
    end
    if (ram_wEn === 1'b1 && ram_addr === 12'd64 && ram_dataIn[31] === 1'b1) begin
      wr_cnt++; wr_cyc = cyc; wr_data = ram_dataIn;
    end
    if (cpu_stall === 1'b1) begin
      st_cnt++; st_cyc = cyc;
    end
    @(posedge clk);
    if (reset) begin
      m_pend = '0; m_full = 0; m_arb = 0; m_wait = 0; m_ovf = 0;
      regs_known = 1;
    end else begin
      old_nonempty = (m_pend != 0);
      old_full     = m_full;
      lost = 0;
      for (int i = 0; i < 16; i++)
        if (btn_pulse[i] && m_pend[i] && !(g && i == sel)) lost++;
      m_ovf = (m_ovf + lost > 255) ? 255 : m_ovf + lost;
      np = m_pend;
      if (g) np[sel] = 1'b0;
      m_pend = np | btn_pulse;
      if (g) m_full = 1;
      else if (cpu_mem_en && cpu_wEn && cpu_addr == 12'd64) m_full = cpu_dataIn[31];
      if (m_arb) begin
        if (g) begin m_arb = 0; m_wait = 0; end
        else m_wait++;
      end else if (old_nonempty && !old_full) begin
        m_arb = 1;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic pulse(input logic [15:0] b);
    btn_pulse = b; pc = cyc;
    cycle();
    btn_pulse = '0;
  endtask

  task automatic cpu_clear();
    cpu_mem_en = 1; cpu_wEn = 1; cpu_addr = 12'd64; cpu_dataIn = '0; clr = cyc;
    cycle();
    cpu_mem_en = 0; cpu_wEn = 0; cpu_addr = '0;
  endtask

  task automatic wait_wr(input string tag, input int budget);
    int n0;
    int k;
    n0 = wr_cnt; k = 0;
    while (wr_cnt == n0 && k < budget) begin cycle(); k++; end
    chk({tag, "_written"}, 32'(wr_cnt != n0), 32'd1);
  endtask

  int s0, n0;

  initial begin
    reset = 1; btn_pulse = '0; cpu_mem_en = 0; cpu_wEn = 0; cpu_addr = '0; cpu_dataIn = '0;
    cycle(); cycle();
    chk("rst_evt_full", 32'(evt_full), 32'd0);
    chk("rst_overflow", 32'(overflow_cnt), 32'd0);
    reset = 0;
    cycle(); cycle();

    // Idle CPU: press button 4, mailbox two cycles later.
    pulse(16'h0008);
    wait_wr("idle", 10);
    chk("idle_latency", 32'(wr_cyc), 32'(pc + 2));
    chk("idle_word", wr_data, 32'h8000_0003);
    chk("idle_full", 32'(evt_full), 32'd1);
    cpu_clear();

    // Multiple presses drain lowest first, each two cycles after the clear.
    cycle(); cycle();
    pulse(16'h8011);
    wait_wr("multi0", 10);
    chk("multi0_latency", 32'(wr_cyc), 32'(pc + 2));
    chk("multi0_word", wr_data, 32'h8000_0000);
    cpu_clear();
    wait_wr("multi1", 10);
    chk("multi1_latency", 32'(wr_cyc), 32'(clr + 2));
    chk("multi1_word", wr_data, 32'h8000_0004);
    cpu_clear();
    wait_wr("multi2", 10);
    chk("multi2_latency", 32'(wr_cyc), 32'(clr + 2));
    chk("multi2_word", wr_data, 32'h8000_000F);
    cpu_clear();

    // Starvation: CPU reads every cycle, one forced stall after STARVE_LIMIT waits.
    cycle();
    cpu_mem_en = 1; cpu_wEn = 0; cpu_addr = 12'h123;
    s0 = st_cnt;
    pulse(16'h0010);
    wait_wr("starve", 20);
    chk("starve_wr_cycle", 32'(wr_cyc), 32'(pc + 2 + LIMIT));
    chk("starve_word", wr_data, 32'h8000_0004);
    chk("starve_stall_cycle", 32'(st_cyc), 32'(pc + 2 + LIMIT));
    cycle(); cycle(); cycle();
    chk("starve_stall_once", 32'(st_cnt - s0), 32'd1);
    cpu_mem_en = 0;
    cpu_clear();

    // Overflow: lost presses while the mailbox is full, then saturation.
    cycle();
    pulse(16'h0001);
    wait_wr("ovf_fill", 10);
    pulse(16'h0002); cycle();
    pulse(16'h0002); cycle();
    pulse(16'h0002); cycle();
    chk("ovf_two", 32'(overflow_cnt), 32'd2);
    btn_pulse = 16'h0002;
    for (int i = 0; i < 300; i++) cycle();
    btn_pulse = '0;
    chk("ovf_saturate", 32'(overflow_cnt), 32'd255);
    cpu_clear();
    wait_wr("ovf_pend", 10);
    chk("ovf_pend_latency", 32'(wr_cyc), 32'(clr + 2));
    chk("ovf_pend_word", wr_data, 32'h8000_0001);
    cpu_clear();

    // Reset landing on the forced-grant cycle.
    cycle();
    cpu_mem_en = 1; cpu_wEn = 1; cpu_addr = 12'd100; cpu_dataIn = 32'h1234_5678;
    s0 = st_cnt; n0 = wr_cnt;
    pulse(16'h0040);
    while (cyc < pc + 2 + LIMIT) cycle();
    reset = 1;
    cycle();
    reset = 0;
    cpu_mem_en = 0; cpu_wEn = 0;
    for (int i = 0; i < 6; i++) cycle();
    chk("rst_mid_no_stall", 32'(st_cnt - s0), 32'd0);
    chk("rst_mid_no_write", 32'(wr_cnt - n0), 32'd0);
    chk("rst_mid_full", 32'(evt_full), 32'd0);
    chk("rst_mid_ovf", 32'(overflow_cnt), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      reset      = ($urandom_range(0, 79) == 0);
      btn_pulse  = ($urandom_range(0, 5) == 0) ? 16'($urandom) : 16'h0000;
      cpu_mem_en = ($urandom_range(0, 2) != 0);
      cpu_wEn    = ($urandom_range(0, 1) == 1);
      cpu_addr   = ($urandom_range(0, 3) == 0) ? 12'd64 : 12'($urandom);
      cpu_dataIn = $urandom;
      cycle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/button_event_arbiter.md
# button_event_arbiter

Shares the single data-memory port between the processor and the 16-button input path of the memory game. Button presses are latched into a pending mask. One press at a time is posted to a fixed mailbox word in RAM, using idle CPU memory cycles. If the CPU keeps the port busy, the block stalls the CPU for one cycle to post the event. The block sits between the CPU memory interface and the RAM write/address/data inputs.

## Interface
- `DATA_WIDTH`, 32, RAM word width.
- `ADDRESS_WIDTH`, 12, RAM address width.
- `NUM_BTN`, 16, number of button inputs (index width is 4).
- `EVT_ADDR`, 64, word address of the button-event mailbox.
- `STARVE_LIMIT`, 8, consecutive busy CPU cycles tolerated before a forced stall (≥1).

- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `btn_pulse`  in  NUM_BTN  one-cycle press pulses; bit i = button i+1.
- `cpu_mem_en`  in  1  CPU performs a memory access this cycle.
- `cpu_wEn`  in  1  CPU write enable.
- `cpu_addr`  in  ADDRESS_WIDTH  CPU address.
- `cpu_dataIn`  in  DATA_WIDTH  CPU write data.
- `cpu_stall`  out  1  CPU must hold its access and reissue it next cycle.
- `ram_wEn`  out  1  to RAM `wEn`.
- `ram_addr`  out  ADDRESS_WIDTH  to RAM `addr`.
- `ram_dataIn`  out  DATA_WIDTH  to RAM `dataIn`.
- `evt_full`  out  1  mailbox holds an unconsumed event.
- `overflow_cnt`  out  8  presses lost, saturating.

## Operation
- **Pending mask `pend[NUM_BTN-1:0]`.**
  - `btn_pulse[i]`=1 sets `pend[i]` at the next edge.
  - If `pend[i]` is already set and not being cleared this cycle, the press is lost and `overflow_cnt` increments (saturates at 255).
- **Selection.** The selected event is the lowest set index of `pend`. Its bit clears on the block's write cycle. A pulse on that same bit in that same cycle leaves it set, with no overflow.
- **Mailbox word.** The block writes `32'h8000_0000 | idx` (idx 0..15 in bits [3:0]).
- **`evt_full` tracking.**
  - The block's own mailbox write sets `evt_full`.
  - Any CPU write (`cpu_mem_en`&`cpu_wEn`) to `EVT_ADDR` loads `evt_full` <= `cpu_dataIn[31]`. Firmware consumes an event by writing 0.
  - CPU reads never change `evt_full`.
- **FSM.**
  - IDLE: go to ARB when `pend`≠0 and `evt_full`=0.
  - ARB, `cpu_mem_en`=0: grant. The block drives `ram_wEn`=1, `ram_addr`=`EVT_ADDR`, `ram_dataIn`=mailbox word. Next state IDLE; `wait_cnt` cleared.
  - ARB, `cpu_mem_en`=1 and `wait_cnt`<`STARVE_LIMIT`: pass the CPU access through and increment `wait_cnt`.
  - ARB, `cpu_mem_en`=1 and `wait_cnt`==`STARVE_LIMIT`: forced grant. `cpu_stall`=1 and the block drives the same write as above. Next state IDLE; `wait_cnt` cleared.
- **Pass-through.** In all non-grant cycles, `ram_*` equal the `cpu_*` inputs combinationally, with `ram_wEn` = `cpu_mem_en`&`cpu_wEn`.
- **Non-goal.** RAM contents are not reset by this block.

## Timing
- **Reset values.** Reset held at an edge gives: state IDLE, `pend`=0, `evt_full`=0, `wait_cnt`=0, `overflow_cnt`=0.
- **Reset gating.** While `reset`=1, `cpu_stall`=0 and pass-through is forced combinationally. This also applies to a reset arriving mid-ARB.
- **Latency.** A pulse at edge-cycle T gives `pend` set at T+1 and ARB at T+2. The earliest mailbox write is cycle T+2, provided the CPU is idle and `evt_full`=0.
- **Back-to-back events.** After a write, `evt_full`=1 blocks further writes until the CPU writes 0. The earliest next write is 2 cycles after that CPU clear (clear edge, then ARB).
- **Worst-case post delay.** `STARVE_LIMIT`+1 cycles in ARB.
- **Stall.** `cpu_stall` lasts exactly one cycle per forced grant and is never asserted outside ARB.
- **Stalled-cycle semantics.** The CPU access in a stalled cycle has no effect, including on `evt_full` snooping.
- **Simultaneous events.** A CPU write of 0 to `EVT_ADDR` in the cycle `evt_full` goes 1→… is impossible: the block owns the port that cycle.

## Test plan
- **Idle CPU.** Reset, then pulse `btn_pulse`=16'h0008 at cycle 5, with `cpu_mem_en`=0 → cycle 7: `ram_wEn`=1, `ram_addr`=64, `ram_dataIn`=32'h8000_0003. `evt_full`=1 from cycle 8.
- **Multiple presses, ordered draining.** Pulse 16'h8011, then CPU writes 0 to addr 64 after each event → mailbox values 0x80000000, 0x80000004, 0x8000000F in that order. Each write is 2 cycles after the preceding clear.
- **Starvation.** One press with `cpu_mem_en`=1 held continuously, `STARVE_LIMIT`=8 → `cpu_stall`=1 for exactly one cycle, 8 cycles after ARB entry. The block's write appears that cycle, and the CPU address is passed through on all other cycles.
- **Overflow.** Pulse button 2 three times while `evt_full`=1 → `pend[1]`=1 and `overflow_cnt`=2. Then 300 repeat pulses → `overflow_cnt`=255.
- **Reset mid-operation.** Assert `reset` in the forced-grant cycle → `cpu_stall`=0 and CPU pass-through in that cycle. Next cycle: state IDLE, `pend`=0, `evt_full`=0, and no further mailbox write.
